// File: rtl/ncl_mult_seq.sv
// Sequential WxW dual-rail multiplier with four-phase DATA/NULL handshake.
// Shift-add over W cycles; optional two's-complement mode and sticky illegal-code flag.
module ncl_mult_seq #(
    parameter int W      = 3,
    parameter bit SIGNED = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   a_rail1,
    input  logic [W-1:0]   a_rail0,
    input  logic [W-1:0]   b_rail1,
    input  logic [W-1:0]   b_rail0,
    input  logic           ki,
    output logic [2*W-1:0] p_rail1,
    output logic [2*W-1:0] p_rail0,
    output logic           ko,
    output logic           err
);

    localparam int PW = 2 * W;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_NULL = 2'd0,
        S_CALC = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   p1_q, p1_d;
    logic [PW-1:0]   p0_q, p0_d;
    logic            ko_q, ko_d;
    logic            err_q, err_d;

    logic            in_illegal_s;
    logic            in_complete_s;
    logic            in_allnull_s;
    logic            a_msb_s;
    logic            last_s;
    logic [PW-1:0]   partial_s;
    logic [PW-1:0]   sum_s;

    assign in_illegal_s  = (|(a_rail1 & a_rail0)) | (|(b_rail1 & b_rail0));
    assign in_complete_s = (&(a_rail1 ^ a_rail0)) & (&(b_rail1 ^ b_rail0));
    assign in_allnull_s  = ~(|{a_rail1, a_rail0, b_rail1, b_rail0});
    assign a_msb_s       = SIGNED ? a_rail1[W-1] : 1'b0;
    assign last_s        = (cnt_q == CW'(1));
    assign partial_s     = mplier_q[0] ? mcand_q : {PW{1'b0}};
    // In signed mode the multiplier MSB carries weight -2^(W-1), so its row is subtracted.
    assign sum_s         = (SIGNED && last_s) ? (acc_q - partial_s) : (acc_q + partial_s);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_NULL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_NULL: begin
                if (!in_illegal_s && in_complete_s && ki) begin
                    state_d = S_CALC;
                end else begin
                    state_d = S_NULL;
                end
            end
            S_CALC: begin
                if (last_s) begin
                    state_d = S_OUT;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_OUT: begin
                if (!ki && in_allnull_s) begin
                    state_d = S_NULL;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: state_d = S_NULL;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        p1_d     = p1_q;
        p0_d     = p0_q;
        ko_d     = ko_q;
        err_d    = err_q;
        case (state_q)
            S_NULL: begin
                p1_d = {PW{1'b0}};
                p0_d = {PW{1'b0}};
                ko_d = 1'b0;
                if (in_illegal_s) begin
                    err_d = 1'b1;
                end else if (in_complete_s && ki) begin
                    mcand_d  = {{W{a_msb_s}}, a_rail1};
                    mplier_d = b_rail1;
                    acc_d    = {PW{1'b0}};
                    cnt_d    = CW'(W);
                    ko_d     = 1'b1;
                end else begin
                    err_d = err_q;
                end
            end
            S_CALC: begin
                acc_d    = sum_s;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (last_s) begin
                    p1_d = sum_s;
                    p0_d = ~sum_s;
                end else begin
                    p1_d = p1_q;
                    p0_d = p0_q;
                end
            end
            S_OUT: begin
                if (in_illegal_s) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (!ki && in_allnull_s) begin
                    p1_d = {PW{1'b0}};
                    p0_d = {PW{1'b0}};
                    ko_d = 1'b0;
                end else begin
                    ko_d = ko_q;
                end
            end
            default: begin
                p1_d = {PW{1'b0}};
                p0_d = {PW{1'b0}};
                ko_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= {PW{1'b0}};
            mplier_q <= {W{1'b0}};
            cnt_q    <= {CW{1'b0}};
            acc_q    <= {PW{1'b0}};
            p1_q     <= {PW{1'b0}};
            p0_q     <= {PW{1'b0}};
            ko_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            p1_q     <= p1_d;
            p0_q     <= p0_d;
            ko_q     <= ko_d;
            err_q    <= err_d;
        end
    end

    assign p_rail1 = p1_q;
    assign p_rail0 = p0_q;
    assign ko      = ko_q;
    assign err     = err_q;

endmodule

// File: tb/tb_ncl_mult_seq.sv
// Directed bench for ncl_mult_seq: W=3 unsigned, W=3 signed and W=8 unsigned instances.
module tb_ncl_mult_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0]  u_a1, u_a0, u_b1, u_b0;
    logic        u_ki, u_ko, u_err;
    logic [5:0]  u_p1, u_p0;
    logic [2:0]  s_a1, s_a0, s_b1, s_b0;
    logic        s_ki, s_ko, s_err;
    logic [5:0]  s_p1, s_p0;
    logic [7:0]  w_a1, w_a0, w_b1, w_b0;
    logic        w_ki, w_ko, w_err;
    logic [15:0] w_p1, w_p0;

    ncl_mult_seq #(.W(3), .SIGNED(1'b0)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .a_rail1(u_a1), .a_rail0(u_a0), .b_rail1(u_b1), .b_rail0(u_b0),
        .ki(u_ki), .p_rail1(u_p1), .p_rail0(u_p0), .ko(u_ko), .err(u_err));
    ncl_mult_seq #(.W(3), .SIGNED(1'b1)) u_dut3s (
        .clk(clk), .rst_n(rst_n), .a_rail1(s_a1), .a_rail0(s_a0), .b_rail1(s_b1), .b_rail0(s_b0),
        .ki(s_ki), .p_rail1(s_p1), .p_rail0(s_p0), .ko(s_ko), .err(s_err));
    ncl_mult_seq #(.W(8), .SIGNED(1'b0)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a_rail1(w_a1), .a_rail0(w_a0), .b_rail1(w_b1), .b_rail0(w_b0),
        .ki(w_ki), .p_rail1(w_p1), .p_rail0(w_p0), .ko(w_ko), .err(w_err));

    int n_checks = 0;
    int n_fail   = 0;
    int sel      = 0;

    logic [15:0] p1_sel, p0_sel;
    logic        ko_sel, err_sel;

    always_comb begin
        p1_sel  = 16'd0;
        p0_sel  = 16'd0;
        ko_sel  = 1'b0;
        err_sel = 1'b0;
        case (sel)
            0: begin p1_sel = {10'd0, u_p1}; p0_sel = {10'd0, u_p0}; ko_sel = u_ko; err_sel = u_err; end
            1: begin p1_sel = {10'd0, s_p1}; p0_sel = {10'd0, s_p0}; ko_sel = s_ko; err_sel = s_err; end
            default: begin p1_sel = w_p1; p0_sel = w_p0; ko_sel = w_ko; err_sel = w_err; end
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (dut %0d, t=%0t)", tag, obs, exp, sel, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input int s, input logic [7:0] a1, input logic [7:0] a0,
                          input logic [7:0] b1, input logic [7:0] b0, input logic k);
        case (s)
            0: begin u_a1 = a1[2:0]; u_a0 = a0[2:0]; u_b1 = b1[2:0]; u_b0 = b0[2:0]; u_ki = k; end
            1: begin s_a1 = a1[2:0]; s_a0 = a0[2:0]; s_b1 = b1[2:0]; s_b0 = b0[2:0]; s_ki = k; end
            default: begin w_a1 = a1; w_a0 = a0; w_b1 = b1; w_b0 = b0; w_ki = k; end
        endcase
    endtask

    // Full handshake: capture, W calc edges, hold with NULL inputs, NULL return.
    task automatic run_op(input int s, input int w, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp);
        logic [15:0] mask;
        mask = (w == 8) ? 16'hFFFF : 16'h003F;
        sel = s;
        set_in(s, a, ~a, b, ~b, 1'b1);
        tick();
        check_eq("ko_after_capture", {31'd0, ko_sel}, 32'd1);
        check_eq("p_null_at_capture", {p1_sel, p0_sel}, 32'd0);
        for (int i = 1; i < w; i++) begin
            tick();
            check_eq("p_null_during_calc", {p1_sel, p0_sel}, 32'd0);
        end
        tick();
        check_eq("p_rail1_data", {16'd0, p1_sel}, {16'd0, exp});
        check_eq("p_rail0_data", {16'd0, p0_sel}, {16'd0, ~exp & mask});
        set_in(s, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
        tick();
        check_eq("p_held_ki1", {16'd0, p1_sel}, {16'd0, exp});
        check_eq("ko_held_ki1", {31'd0, ko_sel}, 32'd1);
        set_in(s, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        tick();
        check_eq("p_null_return", {p1_sel, p0_sel}, 32'd0);
        check_eq("ko_null_return", {31'd0, ko_sel}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) set_in(s, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        tick();
        tick();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check_eq("reset_p", {p1_sel, p0_sel}, 32'd0);
            check_eq("reset_ko_err", {30'd0, ko_sel, err_sel}, 32'd0);
        end
        rst_n = 1'b1;
        tick();

        run_op(0, 3, 8'd5, 8'd4, 16'd20);
        run_op(0, 3, 8'd6, 8'd7, 16'd42);
        run_op(0, 3, 8'd7, 8'd1, 16'd7);
        run_op(0, 3, 8'd0, 8'd0, 16'd0);

        // COMPLETE but ki=0: no capture
        sel = 0;
        set_in(0, 8'd5, 8'd2, 8'd3, 8'd4, 1'b0);
        tick();
        tick();
        check_eq("no_capture_ki0", {31'd0, ko_sel}, 32'd0);

        // Partial DATA: one bit only, no capture and no error
        set_in(0, 8'b001, 8'b000, 8'd0, 8'd0, 1'b1);
        tick();
        tick();
        check_eq("partial_ko", {31'd0, ko_sel}, 32'd0);
        check_eq("partial_err", {31'd0, err_sel}, 32'd0);

        // Illegal code on A bit 1
        set_in(0, 8'b010, 8'b111, 8'b001, 8'b110, 1'b1);
        tick();
        check_eq("illegal_err", {31'd0, err_sel}, 32'd1);
        check_eq("illegal_ko", {31'd0, ko_sel}, 32'd0);
        set_in(0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        tick();
        run_op(0, 3, 8'd3, 8'd2, 16'd6);
        check_eq("err_sticky", {31'd0, err_sel}, 32'd1);

        run_op(1, 3, 8'b101, 8'b010, 16'b111010);
        run_op(1, 3, 8'b100, 8'b100, 16'b010000);
        run_op(1, 3, 8'b011, 8'b101, 16'b110111);
        check_eq("signed_err_clear", {31'd0, err_sel}, 32'd0);

        run_op(2, 8, 8'd255, 8'd255, 16'hFE01);
        run_op(2, 8, 8'd200, 8'd3, 16'd600);

        // Reset during calc cycle 2 of the W=8 instance
        sel = 2;
        set_in(2, 8'd77, ~8'd77, 8'd99, ~8'd99, 1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check_eq("midcalc_reset_p", {p1_sel, p0_sel}, 32'd0);
        check_eq("midcalc_reset_ko_err", {30'd0, ko_sel, err_sel}, 32'd0);
        sel = 0;
        #1;
        check_eq("reset_clears_err", {31'd0, err_sel}, 32'd0);
        rst_n = 1'b1;
        set_in(2, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        tick();
        run_op(2, 8, 8'd3, 8'd3, 16'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
